dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU datapath) and port 1 (debug/loader unit).
- Selects one access per cycle using round-robin priority, with an optional bounded lock so port 1 can burst.
- Drives the memory's read/write strobes, address and write data.
- Returns read data to the requester that issued the read, one cycle later.

Parameters:
- ADDRESS_BITS, 11, memory address width.
- DATA_BITS, 16, memory data width.
- MAX_LOCK, 16, maximum consecutive cycles a locked owner may hold the memory (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_rN_req  input  1  requester N (N = 0, 1) wants an access this cycle.
- i_rN_we  input  1  1 = write, 0 = read.
- i_rN_lock  input  1  requester N asks to keep ownership after its grant.
- i_rN_addr  input  ADDRESS_BITS  access address.
- i_rN_wdata  input  DATA_BITS  write data.
- o_rN_gnt  output  1  access accepted this cycle (combinational).
- o_rN_rvalid  output  1  read data for requester N valid this cycle (registered).
- o_rN_rdata  output  DATA_BITS  read data; equals i_mem_data when o_rN_rvalid = 1, else 0.
- o_mem_read  output  1  memory read strobe.
- o_mem_write  output  1  memory write strobe.
- o_mem_address  output  ADDRESS_BITS  memory address.
- o_mem_data  output  DATA_BITS  memory write data.
- i_mem_data  input  DATA_BITS  memory registered read data.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = IDLE, last = 1 (port 0 favoured first), lock_cnt = 0, both rvalid = 0.
- Reset outputs: gnt = 0, mem strobes = 0, o_mem_address = 0, o_mem_data = 0.
- Grant is combinational from registered state and current requests. At most one gnt per cycle; a request is held by the requester until granted.
- IDLE grant rules:
  - Single request: granted.
  - Both requesting: grant the port != last.
  - A grant updates last to the granted port at the clock edge.
- OWN_N states: only port N may be granted; the other port's request waits, gnt = 0.
- State transitions:
  - IDLE -> OWN_N when port N is granted with i_rN_lock = 1; lock_cnt <= 1.
  - OWN_N, each cycle: lock_cnt increments whether or not N requests.
  - OWN_N -> IDLE when i_rN_lock = 0 at the edge, or lock_cnt = MAX_LOCK-1 at the edge (forced release). lock_cnt <= 0.
  - After a forced release, last = N, so the other port wins if both request.
- Memory side: the granted port's addr and wdata are muxed onto o_mem_address / o_mem_data. o_mem_read = gnt & !we; o_mem_write = gnt & we. Never both strobes set.
- When no port is granted, address and data hold 0 and both strobes are 0.
- Read latency: memory samples at edge T. o_rN_rvalid <= gnt_N & !we_N, high for exactly one cycle (T+1). o_rN_rdata passes i_mem_data during that cycle.
- Back-to-back reads to different ports: each rvalid pulse routes to the correct port; no data loss.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset mid-operation: pending rvalid is dropped, lock is cleared, the memory array is not affected.

Test Plan:
- Reset, then port 0 reads addr 0x005 (preloaded 0xBEEF): o_r0_gnt = 1 same cycle, o_mem_read = 1, o_r0_rvalid = 1 next cycle with o_r0_rdata = 0xBEEF; port 1 rvalid stays 0.
- Both ports request reads every cycle: grants alternate 0,1,0,1 starting with port 0; each rvalid pulse lands on the correct port with correct data.
- Port 1 writes 0x1234 to 0x010 (gnt same cycle, o_mem_write = 1), then port 0 reads 0x010 -> rdata 0x1234.
- Port 1 granted with lock held high and port 0 requesting continuously: port 0 gets no gnt for exactly MAX_LOCK (16) cycles, then is granted on the next cycle.
- Port 1 lock dropped after 3 cycles: port 0 is granted on the following cycle; lock_cnt returns to 0.
- rst_n pulsed low the cycle after a port 0 read grant: o_r0_rvalid = 0 immediately; after release, both ports requesting -> port 0 granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter with bounded lock for a shared single-port data memory
//
// Purpose:
//   Two requesters share one single-port data memory. Port 0 is the CPU
//   datapath, port 1 the debug/loader unit. One access is granted per cycle
//   under round-robin priority. A granted requester may ask to keep ownership
//   (lock), which is forcibly released after MAX_LOCK consecutive cycles.
//   Read data is routed back to the requester that issued the read, one
//   cycle after the grant.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   i_rN_req / i_rN_we         request and write-enable of requester N
//   i_rN_lock                  requester N asks to keep ownership after its grant
//   i_rN_addr / i_rN_wdata     access address and write data of requester N
//   o_rN_gnt                   combinational grant to requester N
//   o_rN_rvalid / o_rN_rdata   registered read-return pulse and its data
//   o_mem_read / o_mem_write   memory strobes (never both high)
//   o_mem_address / o_mem_data memory address and write data (0 when idle)
//   i_mem_data                 registered read data from the memory

module dmem_arbiter #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int MAX_LOCK     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    i_r0_req,
  input  logic                    i_r0_we,
  input  logic                    i_r0_lock,
  input  logic [ADDRESS_BITS-1:0] i_r0_addr,
  input  logic [DATA_BITS-1:0]    i_r0_wdata,
  output logic                    o_r0_gnt,
  output logic                    o_r0_rvalid,
  output logic [DATA_BITS-1:0]    o_r0_rdata,

  input  logic                    i_r1_req,
  input  logic                    i_r1_we,
  input  logic                    i_r1_lock,
  input  logic [ADDRESS_BITS-1:0] i_r1_addr,
  input  logic [DATA_BITS-1:0]    i_r1_wdata,
  output logic                    o_r1_gnt,
  output logic                    o_r1_rvalid,
  output logic [DATA_BITS-1:0]    o_r1_rdata,

  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic [ADDRESS_BITS-1:0] o_mem_address,
  output logic [DATA_BITS-1:0]    o_mem_data,
  input  logic [DATA_BITS-1:0]    i_mem_data
);

  // Counter must be able to hold MAX_LOCK-1, the forced-release value.
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            r0_rvalid_q, r0_rvalid_d;
  logic            r1_rvalid_q, r1_rvalid_d;

  logic            gnt0;
  logic            gnt1;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  // In IDLE a lone requester always wins; on contention the port that was
  // not served last wins. While a port owns the memory only it can be
  // granted. Grants are forced low while reset is asserted so nothing
  // reaches the memory during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        gnt0 = i_r0_req & (~i_r1_req | last_q);
        gnt1 = i_r1_req & (~i_r0_req | ~last_q);
      end
      OWN0:    gnt0 = i_r0_req;
      OWN1:    gnt1 = i_r1_req;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
    gnt0 = gnt0 & rst_n;
    gnt1 = gnt1 & rst_n;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lock_cnt_d  = lock_cnt_q;
    r0_rvalid_d = gnt0 & ~i_r0_we;
    r1_rvalid_d = gnt1 & ~i_r1_we;

    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (gnt0 && i_r0_lock) begin
          state_d    = OWN0;
          lock_cnt_d = CW'(1);
        end else if (gnt1 && i_r1_lock) begin
          state_d    = OWN1;
          lock_cnt_d = CW'(1);
        end
      end
      OWN0: begin
        // Ownership time runs whether or not the owner is requesting.
        if (!i_r0_lock || lock_cnt_q == LOCK_LAST) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          last_d     = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      OWN1: begin
        if (!i_r1_lock || lock_cnt_q == LOCK_LAST) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          last_d     = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // last resets to 1 so that port 0 is favoured on the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      lock_cnt_q  <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Requester-side outputs
  // ---------------------------------------------------------------------------
  assign o_r0_gnt    = gnt0;
  assign o_r1_gnt    = gnt1;
  assign o_r0_rvalid = r0_rvalid_q;
  assign o_r1_rvalid = r1_rvalid_q;
  // Memory read data is registered, so it lines up with the rvalid pulse.
  assign o_r0_rdata  = r0_rvalid_q ? i_mem_data : '0;
  assign o_r1_rdata  = r1_rvalid_q ? i_mem_data : '0;

  // ---------------------------------------------------------------------------
  // Memory-side outputs
  // ---------------------------------------------------------------------------
  assign o_mem_read  = (gnt0 & ~i_r0_we) | (gnt1 & ~i_r1_we);
  assign o_mem_write = (gnt0 &  i_r0_we) | (gnt1 &  i_r1_we);

  always_comb begin
    o_mem_address = '0;
    o_mem_data    = '0;
    if (gnt0) begin
      o_mem_address = i_r0_addr;
      o_mem_data    = i_r0_wdata;
    end else if (gnt1) begin
      o_mem_address = i_r1_addr;
      o_mem_data    = i_r1_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_we, r0_lock;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_req, r1_we, r1_lock;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDRESS_BITS(AW), .DATA_BITS(DW), .MAX_LOCK(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_lock(r0_lock),
    .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
    .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata),
    .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_lock(r1_lock),
    .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
    .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata),
    .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_address(mem_address), .o_mem_data(mem_data),
    .i_mem_data(mem_rdata)
  );

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data;
    if (mem_read)  mem_rdata <= mem[mem_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic p0(input logic req, input logic we, input logic lock,
                    input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic p1(input logic req, input logic we, input logic lock,
                    input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hA000 | DW'(i);
    mem[5] = 16'hBEEF;
    mem_rdata = '0;
    rst_n = 1'b0;
    p0(0, 0, 0, '0, '0);
    p1(0, 0, 0, '0, '0);

    // Reset state
    tick(); #1;
    check("rst_gnt0", r0_gnt, 0);
    check("rst_gnt1", r1_gnt, 0);
    check("rst_rvalid0", r0_rvalid, 0);
    check("rst_rvalid1", r1_rvalid, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);
    p0(1, 0, 0, 11'h005, '0);
    #1;
    check("rst_gnt0_req", r0_gnt, 0);
    check("rst_read_req", mem_read, 0);
    check("rst_write_req", mem_write, 0);
    p0(0, 0, 0, '0, '0);
    tick(); rst_n = 1'b1;

    // Port 0 read of preloaded 0x005
    tick(); p0(1, 0, 0, 11'h005, '0); #1;
    check("rd0_gnt0", r0_gnt, 1);
    check("rd0_gnt1", r1_gnt, 0);
    check("rd0_read", mem_read, 1);
    check("rd0_write", mem_write, 0);
    check("rd0_addr", mem_address, 11'h005);
    tick(); p0(0, 0, 0, '0, '0); #1;
    check("rd0_rvalid0", r0_rvalid, 1);
    check("rd0_rdata0", r0_rdata, 16'hBEEF);
    check("rd0_rvalid1", r1_rvalid, 0);
    check("rd0_rdata1", r1_rdata, 0);
    check("rd0_idle_addr", mem_address, 0);
    tick(); #1;
    check("rd0_pulse_end", r0_rvalid, 0);
    check("rd0_rdata_zero", r0_rdata, 0);

    // Port 1 write then port 0 reads the same address on the next cycle
    tick(); p1(1, 1, 0, 11'h010, 16'h1234); #1;
    check("wr1_gnt1", r1_gnt, 1);
    check("wr1_write", mem_write, 1);
    check("wr1_read", mem_read, 0);
    check("wr1_addr", mem_address, 11'h010);
    check("wr1_data", mem_data, 16'h1234);
    tick(); p1(0, 0, 0, '0, '0); p0(1, 0, 0, 11'h010, '0); #1;
    check("raw_gnt0", r0_gnt, 1);
    check("wr1_no_rvalid", r1_rvalid, 0);
    tick(); p0(0, 0, 0, '0, '0); p1(1, 0, 0, 11'h020, '0); #1;
    check("raw_rvalid0", r0_rvalid, 1);
    check("raw_rdata0", r0_rdata, 16'h1234);
    check("rd1_gnt1", r1_gnt, 1);
    tick(); p1(0, 0, 0, '0, '0); #1;
    check("rd1_rvalid1", r1_rvalid, 1);
    check("rd1_rdata1", r1_rdata, 16'hA020);
    check("rd1_rvalid0", r0_rvalid, 0);

    // Both ports read every cycle: 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      tick(); p0(1, 0, 0, 11'h031, '0); p1(1, 0, 0, 11'h032, '0); #1;
      check($sformatf("alt%0d_gnt0", k), r0_gnt, (k % 2) == 0);
      check($sformatf("alt%0d_gnt1", k), r1_gnt, (k % 2) == 1);
      if (k > 0) begin
        check($sformatf("alt%0d_rvalid0", k), r0_rvalid, (k % 2) == 1);
        check($sformatf("alt%0d_rvalid1", k), r1_rvalid, (k % 2) == 0);
        check($sformatf("alt%0d_rdata", k), r0_rdata | r1_rdata,
              ((k % 2) == 1) ? 16'hA031 : 16'hA032);
      end
    end
    tick(); p0(0, 0, 0, '0, '0); p1(0, 0, 0, '0, '0); #1;
    check("alt_last_rvalid1", r1_rvalid, 1);
    check("alt_last_rdata1", r1_rdata, 16'hA032);
    check("alt_last_rvalid0", r0_rvalid, 0);

    // Port 0 write so that port 1 wins the next contention
    tick(); p0(1, 1, 0, 11'h040, 16'h5555); #1;
    check("wr0_gnt0", r0_gnt, 1);
    check("wr0_write", mem_write, 1);

    // Port 1 locks continuously: forced release after MAX_LOCK cycles
    tick(); p0(1, 0, 0, 11'h005, '0); p1(1, 0, 1, 11'h020, '0); #1;
    check("lk_c0_gnt1", r1_gnt, 1);
    check("lk_c0_gnt0", r0_gnt, 0);
    for (int i = 1; i < 16; i++) begin
      tick(); #1;
      check($sformatf("lk_c%0d_gnt0", i), r0_gnt, 0);
      check($sformatf("lk_c%0d_gnt1", i), r1_gnt, 1);
      check($sformatf("lk_c%0d_cnt", i), dut.lock_cnt_q, i);
    end
    tick(); p1(1, 0, 1, 11'h020, '0); #1;
    check("lk_rel_gnt0", r0_gnt, 1);
    check("lk_rel_gnt1", r1_gnt, 0);
    check("lk_rel_cnt", dut.lock_cnt_q, 0);
    check("lk_rel_addr", mem_address, 11'h005);
    tick(); p0(0, 0, 0, '0, '0); p1(0, 0, 0, '0, '0); #1;
    check("lk_rel_rdata0", r0_rdata, 16'hBEEF);

    // Port 1 drops lock after 3 cycles
    tick(); p0(1, 0, 0, 11'h031, '0); p1(1, 0, 1, 11'h020, '0); #1;
    check("ld_c0_gnt1", r1_gnt, 1);
    check("ld_c0_gnt0", r0_gnt, 0);
    tick(); #1;
    check("ld_c1_gnt0", r0_gnt, 0);
    tick(); #1;
    check("ld_c2_gnt0", r0_gnt, 0);
    tick(); p1(0, 0, 0, '0, '0); #1;
    check("ld_c3_gnt0", r0_gnt, 0);
    check("ld_c3_gnt1", r1_gnt, 0);
    check("ld_c3_cnt", dut.lock_cnt_q, 3);
    tick(); #1;
    check("ld_c4_gnt0", r0_gnt, 1);
    check("ld_c4_cnt", dut.lock_cnt_q, 0);
    tick(); p0(0, 0, 0, '0, '0);

    // Reset pulsed the cycle after a port 0 read grant
    tick(); p0(1, 0, 0, 11'h005, '0); #1;
    check("mr_gnt0", r0_gnt, 1);
    tick(); p0(0, 0, 0, '0, '0); #1;
    check("mr_rvalid0_pre", r0_rvalid, 1);
    rst_n = 1'b0; #1;
    check("mr_rvalid0_drop", r0_rvalid, 0);
    check("mr_rdata0_drop", r0_rdata, 0);
    tick(); rst_n = 1'b1; p0(1, 0, 0, 11'h010, '0); p1(1, 0, 0, 11'h040, '0); #1;
    check("mr_post_gnt0", r0_gnt, 1);
    check("mr_post_gnt1", r1_gnt, 0);
    tick(); p0(0, 0, 0, '0, '0); #1;
    check("mr_post2_gnt1", r1_gnt, 1);
    check("mr_post_rvalid0", r0_rvalid, 1);
    check("mr_post_rdata0", r0_rdata, 16'h1234);
    tick(); p1(0, 0, 0, '0, '0); #1;
    check("mr_post_rvalid1", r1_rvalid, 1);
    check("mr_post_rdata1", r1_rdata, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
